// File: rtl/avs_hram_arb_pkg.sv
// Shared types and widths for the two-requester HyperRAM Avalon arbiter.
package avs_hram_arb_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 11;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_R0   = 2'b01;
  localparam logic [1:0] GRANT_R1   = 2'b10;

  // A zero burstcount still moves one beat.
  function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction
endpackage

// File: rtl/avs_hram_arbiter_if.sv
// Avalon-MM burst port; master drives the command, slave answers.
interface avs_hram_arbiter_if;
  import avs_hram_arb_pkg::*;
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (output address, read, write, writedata, burstcount,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, burstcount,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/avs_hram_arb_beatcnt.sv
// Burst beat counter: load burst length, count down on each beat, flag the last one.
module avs_hram_arb_beatcnt
  import avs_hram_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               dec_i,
  output logic               last_o
);
  logic [BURST_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = burst_len(burst_i);
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - BURST_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = dec_i && (cnt_q == BURST_W'(1));
endmodule

// File: rtl/avs_hram_arbiter.sv
// Burst-aware two-requester arbiter in front of the HyperRAM converter slave.
// ARB_FIXED_PRIO_EN: r0 always wins ties instead of round-robin.
module avs_hram_arbiter
  import avs_hram_arb_pkg::*;
(
  input  logic               clk_clk,
  input  logic               reset_reset,
  avs_hram_arbiter_if.slave  r0,
  avs_hram_arbiter_if.slave  r1,
  avs_hram_arbiter_if.master hram,
  output logic [1:0]         grant
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata;
  logic [NUM_REQ-1:0][BURST_W-1:0] req_bc;
  logic [NUM_REQ-1:0]              req_rd, req_wr, req, req_wait, req_rdv;

  assign req_addr  = {r1.address,    r0.address};
  assign req_wdata = {r1.writedata,  r0.writedata};
  assign req_bc    = {r1.burstcount, r0.burstcount};
  assign req_rd    = {r1.read,       r0.read};
  assign req_wr    = {r1.write,      r0.write};
  assign req       = req_rd | req_wr;

  state_t state_q, state_d;
  logic   owner_q, owner_d, win;
  logic   load, dec, last, busy, own_wait, own_rdv;

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~req[0];
`else
  // rr_q holds the index favoured on a tie: the one not served last.
  logic rr_q;
  assign win = (req[0] & req[1]) ? rr_q : req[1];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) rr_q <= 1'b0;
    else if (last)   rr_q <= ~owner_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        load    = 1'b1;
        owner_d = win;
        state_d = req_rd[win] ? RD_CMD : WR_BURST;
      end
      WR_BURST: begin
        dec = req_wr[owner_q] & ~hram.waitrequest;
        if (last) state_d = IDLE;
      end
      RD_CMD: begin
        // A beat landing with the accept cycle still counts.
        dec = hram.readdatavalid;
        if (last)                                       state_d = IDLE;
        else if (req_rd[owner_q] && !hram.waitrequest)  state_d = RD_DATA;
      end
      RD_DATA: begin
        dec = hram.readdatavalid;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  avs_hram_arb_beatcnt u_beatcnt (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .load_i  (load),
    .burst_i (req_bc[win]),
    .dec_i   (dec),
    .last_o  (last)
  );

  assign busy     = (state_q != IDLE);
  assign grant    = busy ? (owner_q ? GRANT_R1 : GRANT_R0) : GRANT_NONE;
  assign own_wait = (state_q == WR_BURST || state_q == RD_CMD) ? hram.waitrequest : 1'b1;
  assign own_rdv  = (state_q == RD_CMD || state_q == RD_DATA) && hram.readdatavalid;

  assign hram.address    = busy ? req_addr[owner_q]  : '0;
  assign hram.writedata  = busy ? req_wdata[owner_q] : '0;
  assign hram.burstcount = busy ? req_bc[owner_q]    : '0;
  assign hram.read       = (state_q == RD_CMD)   && req_rd[owner_q];
  assign hram.write      = (state_q == WR_BURST) && req_wr[owner_q];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_wait[i] = grant[i] ? own_wait : 1'b1;
    assign req_rdv[i]  = grant[i] & own_rdv;
  end

  assign r0.waitrequest   = req_wait[0];
  assign r1.waitrequest   = req_wait[1];
  assign r0.readdatavalid = req_rdv[0];
  assign r1.readdatavalid = req_rdv[1];
  assign r0.readdata      = hram.readdata;
  assign r1.readdata      = hram.readdata;
endmodule

// File: tb/tb_avs_hram_arbiter.sv
// Directed bench: per-cycle vector tables for write/contention, hand sequences for reads and reset.
module tb_avs_hram_arbiter;
  import avs_hram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  always #5 clk = ~clk;

  avs_hram_arbiter_if r0_if ();
  avs_hram_arbiter_if r1_if ();
  avs_hram_arbiter_if hram_if ();

  avs_hram_arbiter dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .r0          (r0_if),
    .r1          (r1_if),
    .hram        (hram_if),
    .grant       (grant)
  );

  typedef struct {
    logic        r0_wr, r1_wr;
    logic [10:0] bc;
    logic [31:0] r0_addr, r1_addr;
    logic        hw_wait;
    logic [1:0]  exp_grant;
    logic        exp_hwr, exp_r0w, exp_r1w;
    logic [31:0] exp_addr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int r0_pulses = 0;
  int r1_pulses = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (r0_if.readdatavalid) r0_pulses++;
      if (r1_if.readdatavalid) r1_pulses++;
      if (hram_if.readdatavalid) begin
        total++;
        if (!(r0_if.readdatavalid || r1_if.readdatavalid)) begin
          bad++;
          $display("FAIL stray_rdv: readdatavalid dropped at t=%0t", $time);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    r0_if.read = 0; r0_if.write = 0; r0_if.address = '0; r0_if.writedata = '0; r0_if.burstcount = '0;
    r1_if.read = 0; r1_if.write = 0; r1_if.address = '0; r1_if.writedata = '0; r1_if.burstcount = '0;
    hram_if.waitrequest = 0; hram_if.readdata = '0; hram_if.readdatavalid = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic r0wr, input logic r1wr, input logic [10:0] bc,
                              input logic [31:0] r0a, input logic [31:0] r1a, input logic hw,
                              input logic [1:0] g, input logic hwr, input logic r0w,
                              input logic r1w, input logic [31:0] a);
    vec_t v;
    v.r0_wr = r0wr; v.r1_wr = r1wr; v.bc = bc; v.r0_addr = r0a; v.r1_addr = r1a;
    v.hw_wait = hw; v.exp_grant = g; v.exp_hwr = hwr; v.exp_r0w = r0w; v.exp_r1w = r1w;
    v.exp_addr = a;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag, input int idx);
    r0_if.write = v.r0_wr; r0_if.burstcount = v.bc; r0_if.address = v.r0_addr;
    r1_if.write = v.r1_wr; r1_if.burstcount = v.bc; r1_if.address = v.r1_addr;
    hram_if.waitrequest = v.hw_wait;
    #1;
    chk($sformatf("%s[%0d]", tag, idx),
        64'({grant, hram_if.read, hram_if.write, r0_if.waitrequest, r1_if.waitrequest, hram_if.address}),
        64'({v.exp_grant, 1'b0, v.exp_hwr, v.exp_r0w, v.exp_r1w, v.exp_addr}));
    tick();
  endtask

  vec_t tbl_wr[$];
  vec_t tbl_ct[$];
  int   p0, p1;

  initial begin
    // r0 writes 4 beats at 0x100, one stall cycle in the middle
    tbl_wr.push_back(mk(1, 0, 4, 32'h100, 0, 0, GRANT_NONE, 0, 1, 1, 0));
    tbl_wr.push_back(mk(1, 0, 4, 32'h100, 0, 0, GRANT_R0,   1, 0, 1, 32'h100));
    tbl_wr.push_back(mk(1, 0, 4, 32'h100, 0, 1, GRANT_R0,   1, 1, 1, 32'h100));
    tbl_wr.push_back(mk(1, 0, 4, 32'h100, 0, 0, GRANT_R0,   1, 0, 1, 32'h100));
    tbl_wr.push_back(mk(1, 0, 4, 32'h100, 0, 0, GRANT_R0,   1, 0, 1, 32'h100));
    tbl_wr.push_back(mk(1, 0, 4, 32'h100, 0, 0, GRANT_R0,   1, 0, 1, 32'h100));
    tbl_wr.push_back(mk(0, 0, 4, 32'h100, 0, 0, GRANT_NONE, 0, 1, 1, 0));

    // both requesters write bursts of 2 back to back
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_NONE, 0, 1, 1, 0));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R0,   1, 0, 1, 32'h200));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R0,   1, 0, 1, 32'h200));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_NONE, 0, 1, 1, 0));
`ifdef ARB_FIXED_PRIO_EN
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R0,   1, 0, 1, 32'h200));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R0,   1, 0, 1, 32'h200));
`else
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R1,   1, 1, 0, 32'h300));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R1,   1, 1, 0, 32'h300));
`endif
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_NONE, 0, 1, 1, 0));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R0,   1, 0, 1, 32'h200));
    tbl_ct.push_back(mk(1, 1, 2, 32'h200, 32'h300, 0, GRANT_R0,   1, 0, 1, 32'h200));
    tbl_ct.push_back(mk(0, 1, 2, 32'h200, 32'h300, 0, GRANT_NONE, 0, 1, 1, 0));
    tbl_ct.push_back(mk(0, 1, 2, 32'h200, 32'h300, 0, GRANT_R1,   1, 1, 0, 32'h300));
    tbl_ct.push_back(mk(0, 1, 2, 32'h200, 32'h300, 0, GRANT_R1,   1, 1, 0, 32'h300));
    tbl_ct.push_back(mk(0, 0, 2, 32'h200, 32'h300, 0, GRANT_NONE, 0, 1, 1, 0));

    // reset state, with a live request present to prove nothing is muxed through
    rst = 1'b1;
    idle_inputs();
    r0_if.write = 1; r0_if.address = 32'h55; r0_if.writedata = 16'h77; r0_if.burstcount = 11'd3;
    #3;
    chk("reset_state",
        64'({grant, hram_if.read, hram_if.write, r0_if.waitrequest, r1_if.waitrequest,
             r0_if.readdatavalid, r1_if.readdatavalid}),
        64'({GRANT_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    chk("reset_bus", 64'({hram_if.address, hram_if.writedata, hram_if.burstcount}), 64'(0));
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    foreach (tbl_wr[i]) apply(tbl_wr[i], "wr4", i);
    do_reset();
    foreach (tbl_ct[i]) apply(tbl_ct[i], "contend", i);
    idle_inputs();
    do_reset();

    // r1 read burst of 8, 3 stall cycles, beats with gaps
    r1_if.read = 1; r1_if.burstcount = 11'd8; r1_if.address = 32'h400;
    hram_if.waitrequest = 1;
    #1;
    chk("rd_arb", 64'(grant), 64'(GRANT_NONE));
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rd_stall", 64'({grant, hram_if.read, r1_if.waitrequest, hram_if.address}),
          64'({GRANT_R1, 1'b1, 1'b1, 32'h400}));
      tick();
    end
    hram_if.waitrequest = 0;
    #1;
    chk("rd_accept", 64'({grant, hram_if.read, r1_if.waitrequest}), 64'({GRANT_R1, 1'b1, 1'b0}));
    tick();
    r1_if.read = 0;
    p0 = r0_pulses; p1 = r1_pulses;
    for (int b = 0; b < 8; b++) begin
      hram_if.readdatavalid = 1; hram_if.readdata = 16'hB000 + 16'(b);
      #1;
      chk("rd_beat", 64'({r1_if.readdata, r1_if.readdatavalid, r1_if.waitrequest, grant}),
          64'({16'hB000 + 16'(b), 1'b1, 1'b1, GRANT_R1}));
      tick();
      hram_if.readdatavalid = 0;
      if (b % 2 == 0 && b != 7) begin
        #1;
        chk("rd_gap", 64'({grant, r1_if.readdatavalid}), 64'({GRANT_R1, 1'b0}));
        tick();
      end
    end
    #1;
    chk("rd_done", 64'(grant), 64'(GRANT_NONE));
    chk("rd_r1_beats", 64'(r1_pulses - p1), 64'(8));
    chk("rd_r0_beats", 64'(r0_pulses - p0), 64'(0));

    // burstcount 0 write is one beat
    r0_if.write = 1; r0_if.burstcount = 11'd0; r0_if.address = 32'h10; r0_if.writedata = 16'h1234;
    tick();
    #1;
    chk("bc0_beat", 64'({grant, hram_if.write, hram_if.writedata, hram_if.burstcount}),
        64'({GRANT_R0, 1'b1, 16'h1234, 11'd0}));
    tick();
    r0_if.write = 0;
    #1;
    chk("bc0_done", 64'({grant, hram_if.write}), 64'({GRANT_NONE, 1'b0}));

    // 1024-beat read, accepted immediately
    r0_if.read = 1; r0_if.burstcount = 11'd1024; r0_if.address = 32'h2000;
    tick();
    tick();
    r0_if.read = 0;
    p0 = r0_pulses;
    hram_if.readdatavalid = 1;
    repeat (1023) tick();
    hram_if.readdatavalid = 0;
    #1;
    chk("bc1024_hold", 64'(grant), 64'(GRANT_R0));
    tick();
    hram_if.readdatavalid = 1;
    tick();
    hram_if.readdatavalid = 0;
    #1;
    chk("bc1024_done", 64'(grant), 64'(GRANT_NONE));
    chk("bc1024_beats", 64'(r0_pulses - p0), 64'(1024));

    // beat in the same cycle the single-beat read is accepted
    r0_if.read = 1; r0_if.burstcount = 11'd1;
    hram_if.waitrequest = 1;
    tick();
    hram_if.waitrequest = 0; hram_if.readdatavalid = 1; hram_if.readdata = 16'hCAFE;
    #1;
    chk("same_cyc", 64'({r0_if.readdatavalid, hram_if.read, r0_if.readdata}), 64'({1'b1, 1'b1, 16'hCAFE}));
    tick();
    hram_if.readdatavalid = 0; r0_if.read = 0;
    #1;
    chk("same_cyc_idle", 64'({grant, hram_if.read}), 64'({GRANT_NONE, 1'b0}));

    // asynchronous reset after 3 of 8 read beats
    r0_if.read = 1; r0_if.burstcount = 11'd8; r0_if.address = 32'h800;
    tick();
    tick();
    r0_if.read = 0;
    hram_if.readdatavalid = 1;
    repeat (3) tick();
    #1;
    chk("pre_rst", 64'({grant, r0_if.readdatavalid}), 64'({GRANT_R0, 1'b1}));
    rst = 1'b1;
    #1;
    chk("rst_async",
        64'({grant, hram_if.read, hram_if.write, r0_if.waitrequest, r1_if.waitrequest,
             r0_if.readdatavalid, r1_if.readdatavalid, hram_if.address}),
        64'({GRANT_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0}));
    hram_if.readdatavalid = 0;
    tick();
    rst = 1'b0;
    r0_if.write = 1; r0_if.burstcount = 11'd1; r0_if.address = 32'h900;
    #1;
    chk("post_rst_idle", 64'(grant), 64'(GRANT_NONE));
    tick();
    #1;
    chk("post_rst_grant", 64'({grant, hram_if.write, hram_if.address}), 64'({GRANT_R0, 1'b1, 32'h900}));
    tick();
    r0_if.write = 0;
    #1;
    chk("post_rst_done", 64'(grant), 64'(GRANT_NONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
